// File: rtl/sb_pkg.sv
// Shared sizing, types and mask helper for the checkpointed busy-table scoreboard.
package sb_pkg;

  localparam int unsigned PRF_SIZE    = 64;
  localparam int unsigned IDX_W       = $clog2(PRF_SIZE);
  localparam int unsigned SET_PORTS   = 4;
  localparam int unsigned CLR_PORTS   = 4;
  localparam int unsigned QUERY_PORTS = 16;
  localparam int unsigned CKPT_NUM    = 4;
  localparam int unsigned CK_W        = $clog2(CKPT_NUM);
  localparam int unsigned LANE_W      = $clog2(SET_PORTS);
  localparam int unsigned MASK_PORTS  = (SET_PORTS > CLR_PORTS) ? SET_PORTS : CLR_PORTS;
  localparam bit          ZERO_HARDWIRED = 1'b1;

  typedef logic [IDX_W-1:0]    preg_idx_t;
  typedef logic [CK_W-1:0]     ckpt_id_t;
  typedef logic [CK_W:0]       ckpt_cnt_t;
  typedef logic [PRF_SIZE-1:0] busy_vec_t;

  // OR-reduce a set of valid index ports into a one-hot-per-port bit mask.
  function automatic busy_vec_t onehot_mask(input logic [MASK_PORTS-1:0] valid,
                                            input preg_idx_t [MASK_PORTS-1:0] idx);
    busy_vec_t m;
    m = '0;
    for (int unsigned i = 0; i < MASK_PORTS; i++) begin
      if (valid[i]) m[idx[i]] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/scoreboard_ckpt_ptr.sv
// Checkpoint ring bookkeeping: head/tail/count, alloc/free/restore and overflow.
module scoreboard_ckpt_ptr
  import sb_pkg::*;
(
  input  logic      clock,
  input  logic      reset,
  input  logic      flush,
  input  logic      alloc_valid,
  input  logic      free_valid,
  input  logic      restore_valid,
  input  ckpt_id_t  restore_id,
  output logic      alloc_ready,
  output ckpt_id_t  alloc_id,
  output logic      snap_we,
  output ckpt_cnt_t count,
  output logic      overflow
);

  ckpt_id_t  head_q, head_d, tail_q, tail_d, head_adv;
  ckpt_cnt_t count_q, count_d;
  logic      ovf_q, ovf_d;
  logic      full, free_ok, alloc_ok;

  // Next-pointer arithmetic; restore overrides allocation and trims younger slots.
  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    ovf_d    = 1'b0;
    snap_we  = 1'b0;
    full     = (count_q == ckpt_cnt_t'(CKPT_NUM));
    free_ok  = free_valid && (count_q != '0);
    alloc_ok = alloc_valid && !full;
    head_adv = free_ok ? ckpt_id_t'(head_q + ckpt_id_t'(1)) : head_q;
    if (restore_valid) begin
      tail_d = restore_id;
      if (free_ok && (restore_id == head_q)) begin
        head_d  = restore_id;
        count_d = '0;
      end else begin
        head_d  = head_adv;
        count_d = ckpt_cnt_t'(ckpt_id_t'(restore_id - head_adv));
      end
    end else begin
      head_d = head_adv;
      if (alloc_ok) begin
        snap_we = 1'b1;
        tail_d  = ckpt_id_t'(tail_q + ckpt_id_t'(1));
      end
      count_d = ckpt_cnt_t'(count_q + ckpt_cnt_t'(alloc_ok) - ckpt_cnt_t'(free_ok));
      ovf_d   = alloc_valid && full;
    end
  end

  // Pointer and overflow registers; reset and flush empty the ring.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign alloc_ready = !full;
  assign alloc_id    = tail_q;
  assign count       = count_q;
  assign overflow    = ovf_q;

endmodule

// File: rtl/scoreboard_ckpt.sv
// PRF busy table with writeback bypass and branch checkpoint snapshots.
module scoreboard_ckpt
  import sb_pkg::*;
(
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush,
  input  logic [SET_PORTS-1:0]         set_valid,
  input  logic [SET_PORTS*IDX_W-1:0]   set_index,
  input  logic [CLR_PORTS-1:0]         clr_valid,
  input  logic [CLR_PORTS*IDX_W-1:0]   clr_index,
  input  logic [QUERY_PORTS*IDX_W-1:0] query_index,
  output logic [QUERY_PORTS-1:0]       query_busy,
  input  logic                         ckpt_alloc_valid,
  input  logic [LANE_W-1:0]            ckpt_alloc_lane,
  output logic                         ckpt_alloc_ready,
  output logic [CK_W-1:0]              ckpt_alloc_id,
  input  logic                         ckpt_free_valid,
  input  logic                         restore_valid,
  input  logic [CK_W-1:0]              restore_id,
  output logic [CK_W:0]                ckpt_count,
  output logic                         ckpt_overflow
);

  localparam busy_vec_t ZERO_MASK = busy_vec_t'(ZERO_HARDWIRED);

  preg_idx_t [SET_PORTS-1:0]   set_idx;
  preg_idx_t [CLR_PORTS-1:0]   clr_idx;
  preg_idx_t [QUERY_PORTS-1:0] query_idx;
  busy_vec_t                   busy_q;
  busy_vec_t                   snap_q [CKPT_NUM];
  busy_vec_t                   set_mask, clr_mask, alloc_mask;
  logic [SET_PORTS-1:0]        lane_keep;
  logic                        snap_we;
  ckpt_id_t                    tail_id;

  assign set_idx   = set_index;
  assign clr_idx   = clr_index;
  assign query_idx = query_index;

  // Set/clear masks; the alloc mask keeps only lanes up to and including the branch.
  always_comb begin
    lane_keep = '0;
    for (int unsigned i = 0; i < SET_PORTS; i++) begin
      lane_keep[i] = (i <= 32'(ckpt_alloc_lane));
    end
    set_mask   = onehot_mask(set_valid, set_idx) & ~ZERO_MASK;
    clr_mask   = onehot_mask(clr_valid, clr_idx);
    alloc_mask = (busy_q & ~clr_mask) |
                 (onehot_mask(set_valid & lane_keep, set_idx) & ~ZERO_MASK);
  end

  // Lookups see same-cycle writeback clears but not same-cycle sets.
  always_comb begin
    query_busy = '0;
    for (int unsigned q = 0; q < QUERY_PORTS; q++) begin
      query_busy[q] = busy_q[query_idx[q]] & ~clr_mask[query_idx[q]];
      if (ZERO_HARDWIRED && (query_idx[q] == '0)) query_busy[q] = 1'b0;
    end
  end

  scoreboard_ckpt_ptr u_ptr (
    .clock         (clock),
    .reset         (reset),
    .flush         (flush),
    .alloc_valid   (ckpt_alloc_valid),
    .free_valid    (ckpt_free_valid),
    .restore_valid (restore_valid),
    .restore_id    (restore_id),
    .alloc_ready   (ckpt_alloc_ready),
    .alloc_id      (tail_id),
    .snap_we       (snap_we),
    .count         (ckpt_count),
    .overflow      (ckpt_overflow)
  );

  assign ckpt_alloc_id = tail_id;

  // Live busy table: restore reloads a snapshot, otherwise clear then set.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      busy_q <= '0;
    end else if (restore_valid) begin
      busy_q <= snap_q[restore_id] & ~clr_mask;
    end else begin
      busy_q <= (busy_q & ~clr_mask) | set_mask;
    end
  end

  // Snapshots track writeback clears; the tail slot is captured on allocation.
  always_ff @(posedge clock) begin
    for (int unsigned k = 0; k < CKPT_NUM; k++) begin
      snap_q[k] <= snap_q[k] & ~clr_mask;
    end
    if (snap_we) snap_q[tail_id] <= alloc_mask;
  end

endmodule
